// File: rtl/shortcut_align_pkg.sv
// Shared definitions for the shortcut alignment block: FSM encoding, beat-count
// width and FIFO depth default. Also provides the FEATURE_WIDTH macro default.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

package shortcut_align_pkg;

  localparam int unsigned BEAT_CNT_W     = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 16;
  localparam int unsigned LANES          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/shortcut_align_if.sv
// Beat-level bus of the shortcut alignment block.
//   x1_*      : main-path (conv result) beats, valid/ready handshake
//   x2_*      : shortcut-path beats, valid/ready handshake
//   feature_* : aligned beat pair towards the adder, valid only (no backpressure)
// master = producer/consumer side (testbench or upstream), slave = aligner.
interface shortcut_align_if #(
  parameter int unsigned FEATURE_WIDTH = `FEATURE_WIDTH
);
  localparam int unsigned BEAT_W = FEATURE_WIDTH * 8;

  logic [BEAT_W-1:0] x1_data_in;
  logic              x1_valid_in;
  logic              x1_ready_out;
  logic [BEAT_W-1:0] x2_data_in;
  logic              x2_valid_in;
  logic              x2_ready_out;
  logic [BEAT_W-1:0] feature_x1_out;
  logic [BEAT_W-1:0] feature_x2_out;
  logic              feature_x_valid_out;

  modport master (
    output x1_data_in, x1_valid_in, x2_data_in, x2_valid_in,
    input  x1_ready_out, x2_ready_out,
    input  feature_x1_out, feature_x2_out, feature_x_valid_out
  );

  modport slave (
    input  x1_data_in, x1_valid_in, x2_data_in, x2_valid_in,
    output x1_ready_out, x2_ready_out,
    output feature_x1_out, feature_x2_out, feature_x_valid_out
  );

endinterface

// File: rtl/shortcut_align_fifo.sv
// align_fifo: single-clock FIFO with registered full/empty flags and occupancy.
//   i_push/i_data : write one entry (caller guarantees !o_full)
//   i_pop         : drop head entry (caller guarantees !o_empty)
//   o_data        : current head entry
//   o_full/o_empty/o_count : registered occupancy status
module align_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_full;
  logic             r_empty;

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    w_count_nxt = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Storage is not reset; occupancy alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_count = r_count;

endmodule

// File: rtl/shortcut_align.sv
// shortcut_align: pairs main-path (x1) beats with shortcut-path (x2) beats for
// a job of total_beats_in pairs and emits them in order to the adder stage.
//   system_clk, rst_n : clock, async active-low reset
//   start_in          : job start pulse, sampled in IDLE with total_beats_in
//   bus (slave)       : x1/x2 valid/ready inputs, aligned pair output
//   busy_out          : high while the job runs
//   done_out          : one-cycle pulse at job end
module shortcut_align
  import shortcut_align_pkg::*;
#(
  parameter int unsigned FEATURE_WIDTH = `FEATURE_WIDTH,
  parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF
) (
  input  logic                  system_clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [BEAT_CNT_W-1:0] total_beats_in,
  shortcut_align_if.slave       bus,
  output logic                  busy_out,
  output logic                  done_out
);

  localparam int unsigned BEAT_W = FEATURE_WIDTH * LANES;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_e                r_state;
  logic [BEAT_CNT_W-1:0] r_total;
  logic [BEAT_CNT_W-1:0] r_acc1;
  logic [BEAT_CNT_W-1:0] r_acc2;
  logic [BEAT_CNT_W-1:0] r_emit;
  logic [BEAT_W-1:0]     r_f1;
  logic [BEAT_W-1:0]     r_f2;
  logic                  r_fv;
  logic                  r_busy;
  logic                  r_done;

  logic                  w_run;
  logic                  w_ready1;
  logic                  w_ready2;
  logic                  w_push1;
  logic                  w_push2;
  logic                  w_pop;
  logic [BEAT_W-1:0]     w_q1;
  logic [BEAT_W-1:0]     w_q2;
  logic                  w_full1;
  logic                  w_full2;
  logic                  w_empty1;
  logic                  w_empty2;
  logic [CNT_W-1:0]      w_cnt1;
  logic [CNT_W-1:0]      w_cnt2;

  // Ready depends on registered state only, never on the valid inputs.
  assign w_run    = (r_state == ST_RUN);
  assign w_ready1 = w_run && !w_full1 && (r_acc1 < r_total);
  assign w_ready2 = w_run && !w_full2 && (r_acc2 < r_total);
  assign w_push1  = bus.x1_valid_in && w_ready1;
  assign w_push2  = bus.x2_valid_in && w_ready2;
  assign w_pop    = w_run && !w_empty1 && !w_empty2 && (r_emit < r_total);

  align_fifo #(.WIDTH(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo_x1 (
    .clk     (system_clk),
    .rst_n   (rst_n),
    .i_push  (w_push1),
    .i_pop   (w_pop),
    .i_data  (bus.x1_data_in),
    .o_data  (w_q1),
    .o_full  (w_full1),
    .o_empty (w_empty1),
    .o_count (w_cnt1)
  );

  align_fifo #(.WIDTH(BEAT_W), .DEPTH(FIFO_DEPTH)) u_fifo_x2 (
    .clk     (system_clk),
    .rst_n   (rst_n),
    .i_push  (w_push2),
    .i_pop   (w_pop),
    .i_data  (bus.x2_data_in),
    .o_data  (w_q2),
    .o_full  (w_full2),
    .o_empty (w_empty2),
    .o_count (w_cnt2)
  );

  // Job FSM, handshake counters and registered pair output.
  always_ff @(posedge system_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_total <= '0;
      r_acc1  <= '0;
      r_acc2  <= '0;
      r_emit  <= '0;
      r_f1    <= '0;
      r_f2    <= '0;
      r_fv    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_fv <= w_pop;
      if (w_pop) begin
        r_f1   <= w_q1;
        r_f2   <= w_q2;
        r_emit <= r_emit + BEAT_CNT_W'(1);
      end
      if (w_push1) r_acc1 <= r_acc1 + BEAT_CNT_W'(1);
      if (w_push2) r_acc2 <= r_acc2 + BEAT_CNT_W'(1);

      case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            r_total <= total_beats_in;
            r_acc1  <= '0;
            r_acc2  <= '0;
            r_emit  <= '0;
            if (total_beats_in != '0) begin
              r_state <= ST_RUN;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Last pair was registered in the previous cycle.
          if (r_emit == r_total) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Occupancy can never leave [0, FIFO_DEPTH].
  assert property (@(posedge system_clk) disable iff (!rst_n)
    (w_cnt1 <= CNT_W'(FIFO_DEPTH)) && (w_cnt2 <= CNT_W'(FIFO_DEPTH)));

  assign bus.x1_ready_out        = w_ready1;
  assign bus.x2_ready_out        = w_ready2;
  assign bus.feature_x1_out      = r_f1;
  assign bus.feature_x2_out      = r_f2;
  assign bus.feature_x_valid_out = r_fv;
  assign busy_out                = r_busy;
  assign done_out                = r_done;

endmodule

// File: tb/tb_shortcut_align.sv
// Self-checking bench for shortcut_align: a queue-based job model checked every
// cycle, plus directed scenarios with hand-derived literal expectations.
module tb_shortcut_align;

  localparam int unsigned FW    = 8;
  localparam int unsigned BW    = FW * 8;
  localparam int          DEPTH = 16;

  logic        system_clk = 1'b0;
  logic        rst_n      = 1'b0;
  logic        start_in   = 1'b0;
  logic [15:0] total_beats_in = '0;
  logic        busy_out;
  logic        done_out;

  shortcut_align_if #(.FEATURE_WIDTH(FW)) bus ();

  shortcut_align #(.FEATURE_WIDTH(FW), .FIFO_DEPTH(DEPTH)) dut (
    .system_clk     (system_clk),
    .rst_n          (rst_n),
    .start_in       (start_in),
    .total_beats_in (total_beats_in),
    .bus            (bus),
    .busy_out       (busy_out),
    .done_out       (done_out)
  );

  always #5 system_clk = ~system_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  logic [63:0] x2_tag = '0;

  // Job model: phase 0 idle, 1 run, 2 done.
  int m_phase = 0, m_total = 0, m_acc1 = 0, m_acc2 = 0, m_emit = 0;
  logic [BW-1:0] q1[$];
  logic [BW-1:0] q2[$];
  logic          m_valid = 1'b0;
  logic [BW-1:0] m_f1 = '0, m_f2 = '0;

  // Per-job observations.
  int t_start = -1, t_acc1 = -1, t_acc2 = -1, t_first_v = -1, t_last_v = -1, t_done = -1;
  int pairs = 0, busy_seen = 0, fall_acc = -1, hs1 = 0, hs2 = 0, viol = 0, done_cnt = 0;
  logic [BW-1:0] first_f1 = '0, first_f2 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge system_clk);
    #1;
  endtask

  function automatic logic [BW-1:0] beat(input int side, input int v);
    return (side == 1) ? BW'(v) : (BW'(v) ^ x2_tag);
  endfunction

  task automatic drive(input int side, input logic v, input logic [BW-1:0] d);
    if (side == 1) begin bus.x1_valid_in = v; bus.x1_data_in = d; end
    else begin bus.x2_valid_in = v; bus.x2_data_in = d; end
  endtask

  // Compare process: check this cycle's outputs, then advance the model.
  initial begin : cmp
    logic r1, r2, p1, p2, pop, fin;
    forever begin
      @(negedge system_clk);
      cyc++;
      if (!rst_n) begin
        chk("rst busy", 64'(busy_out), 64'(0));
        chk("rst valid", 64'(bus.feature_x_valid_out), 64'(0));
        chk("rst f1", 64'(bus.feature_x1_out), 64'(0));
        m_phase = 0; m_total = 0; m_acc1 = 0; m_acc2 = 0; m_emit = 0;
        q1.delete(); q2.delete();
        m_valid = 1'b0; m_f1 = '0; m_f2 = '0;
      end else begin
        r1 = (m_phase == 1) && (q1.size() < DEPTH) && (m_acc1 < m_total);
        r2 = (m_phase == 1) && (q2.size() < DEPTH) && (m_acc2 < m_total);
        chk("busy", 64'(busy_out), 64'(m_phase == 1));
        chk("done", 64'(done_out), 64'(m_phase == 2));
        chk("x1_ready", 64'(bus.x1_ready_out), 64'(r1));
        chk("x2_ready", 64'(bus.x2_ready_out), 64'(r2));
        chk("valid", 64'(bus.feature_x_valid_out), 64'(m_valid));
        chk("pair_x1", bus.feature_x1_out, m_f1);
        chk("pair_x2", bus.feature_x2_out, m_f2);

        if (done_out) done_cnt++;
        if (bus.feature_x_valid_out && !busy_out) viol++;
        if (bus.x1_valid_in && bus.x1_ready_out) hs1++;
        if (bus.x2_valid_in && bus.x2_ready_out) hs2++;
        if (m_valid) begin
          if (t_first_v < 0) begin t_first_v = cyc; first_f1 = m_f1; first_f2 = m_f2; end
          t_last_v = cyc;
          pairs++;
        end
        if (m_phase == 1) busy_seen = 1;
        if (m_phase == 2 && t_done < 0) t_done = cyc;
        if (m_phase == 1 && !r1 && m_acc1 < m_total && fall_acc < 0) fall_acc = m_acc1;

        p1  = bus.x1_valid_in && r1;
        p2  = bus.x2_valid_in && r2;
        if (p1 && t_acc1 < 0) t_acc1 = cyc;
        if (p2 && t_acc2 < 0) t_acc2 = cyc;
        // Only beats already buffered before this edge may pair up.
        pop = (m_phase == 1) && (q1.size() > 0) && (q2.size() > 0) && (m_emit < m_total);
        fin = (m_phase == 1) && (m_emit == m_total);
        m_valid = pop;
        if (pop) begin m_f1 = q1.pop_front(); m_f2 = q2.pop_front(); m_emit++; end
        if (p1) begin q1.push_back(bus.x1_data_in); m_acc1++; end
        if (p2) begin q2.push_back(bus.x2_data_in); m_acc2++; end

        case (m_phase)
          0: if (start_in) begin
               m_total = int'(total_beats_in);
               m_acc1 = 0; m_acc2 = 0; m_emit = 0;
               m_phase = (m_total > 0) ? 1 : 2;
               t_start = cyc; t_acc1 = -1; t_acc2 = -1; t_first_v = -1; t_last_v = -1;
               t_done = -1; pairs = 0; busy_seen = 0; fall_acc = -1; hs1 = 0; hs2 = 0; viol = 0;
             end
          1: if (fin) m_phase = 2;
          default: m_phase = 0;
        endcase
      end
    end
  end

  // Offer n beats on one side, holding each until accepted or the bound expires.
  task automatic send(input int side, input int n, input int base, input int gap_pct,
                      input int delay, input bit expect_all, input int bound);
    logic rdy;
    int   waited;
    repeat (delay) tick();
    for (int k = 0; k < n; k++) begin
      if (!rst_n) begin drive(side, 1'b0, '0); return; end
      if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        drive(side, 1'b0, '0);
        repeat ($urandom_range(3, 1)) tick();
      end
      drive(side, 1'b1, beat(side, base + k));
      waited = 0;
      forever begin
        @(negedge system_clk);
        rdy = (side == 1) ? bus.x1_ready_out : bus.x2_ready_out;
        tick();
        if (!rst_n) begin drive(side, 1'b0, '0); return; end
        if (rdy) break;
        waited++;
        if (waited > bound) begin
          if (expect_all) begin
            n_checks++;
            $display("FAIL side%0d beat %0d: not accepted within %0d cycles", side, k, bound);
          end
          drive(side, 1'b0, '0);
          return;
        end
      end
    end
    drive(side, 1'b0, '0);
  endtask

  task automatic start_job(input int total);
    start_in = 1'b1;
    total_beats_in = 16'(total);
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base_cnt, input int budget);
    int n = 0;
    while (done_cnt == base_cnt && n < budget) begin tick(); n++; end
    if (done_cnt == base_cnt) begin
      n_checks++;
      $display("FAIL %s: done_out not seen within %0d cycles", name, budget);
    end
    tick();
  endtask

  initial begin : main
    int base_cnt;
    int n;
    bus.x1_valid_in = 1'b0; bus.x1_data_in = '0;
    bus.x2_valid_in = 1'b0; bus.x2_data_in = '0;

    // Reset state
    #12;
    chk("reset busy_out", 64'(busy_out), 64'(0));
    chk("reset done_out", 64'(done_out), 64'(0));
    chk("reset x1_ready", 64'(bus.x1_ready_out), 64'(0));
    chk("reset pair_x2", bus.feature_x2_out, 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // Lockstep: 8 pairs (k,k)
    x2_tag = '0;
    base_cnt = done_cnt;
    start_job(8);
    fork
      send(1, 8, 1, 0, 0, 1'b1, 200);
      send(2, 8, 1, 0, 0, 1'b1, 200);
    join
    wait_done("lockstep", base_cnt, 100);
    chki("lockstep pairs", pairs, 8);
    chki("lockstep first latency", t_first_v - ((t_acc1 > t_acc2) ? t_acc1 : t_acc2), 2);
    chki("lockstep done after last", t_done - t_last_v, 1);
    chk("lockstep first pair x1", first_f1, 64'd1);
    chk("lockstep first pair x2", first_f2, 64'd1);
    chk("lockstep last pair held", bus.feature_x1_out, 64'd8);
    tick();

    // Skew: x1 all at once, x2 30 cycles late
    x2_tag = 64'h5A00_0000_0000_0000;
    base_cnt = done_cnt;
    start_job(20);
    fork
      send(1, 20, 100, 0, 0, 1'b1, 200);
      send(2, 20, 100, 0, 30, 1'b1, 200);
    join
    wait_done("skew", base_cnt, 200);
    chki("skew ready fall after", fall_acc, 16);
    chki("skew pairs", pairs, 20);
    chk("skew last pair x2", bus.feature_x2_out, 64'h5A00_0000_0000_0077);
    tick();

    // Zero-length job
    start_job(0);
    chk("zero done_out", 64'(done_out), 64'(1));
    tick();
    chk("zero done_out drops", 64'(done_out), 64'(0));
    chki("zero done latency", t_done - t_start, 1);
    chki("zero busy seen", busy_seen, 0);
    chki("zero pairs", pairs, 0);
    tick();

    // Over-supply: 10 offered, 4 taken
    x2_tag = 64'h0F00_0000_0000_0000;
    base_cnt = done_cnt;
    start_job(4);
    fork
      send(1, 10, 200, 0, 0, 1'b0, 20);
      send(2, 10, 200, 0, 0, 1'b0, 20);
    join
    wait_done("oversupply", base_cnt, 100);
    chki("oversupply x1 accepts", hs1, 4);
    chki("oversupply x2 accepts", hs2, 4);
    chki("oversupply pairs", pairs, 4);
    tick();

    // Reset in the middle of a job
    x2_tag = 64'h3300_0000_0000_0000;
    start_job(10);
    fork
      send(1, 10, 300, 0, 0, 1'b0, 200);
      send(2, 10, 300, 0, 0, 1'b0, 200);
      begin
        n = 0;
        while (pairs < 5 && n < 200) begin @(negedge system_clk); n++; end
        chki("midreset pairs before reset", pairs, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset busy_out", 64'(busy_out), 64'(0));
        chk("midreset valid", 64'(bus.feature_x_valid_out), 64'(0));
        chk("midreset pair_x1", bus.feature_x1_out, 64'(0));
        chk("midreset pair_x2", bus.feature_x2_out, 64'(0));
        chk("midreset x2_ready", 64'(bus.x2_ready_out), 64'(0));
      end
    join
    tick(); tick();
    rst_n = 1'b1;
    tick();
    base_cnt = done_cnt;
    start_job(3);
    fork
      send(1, 3, 400, 0, 0, 1'b1, 200);
      send(2, 3, 400, 0, 0, 1'b1, 200);
    join
    wait_done("after reset", base_cnt, 100);
    chki("after reset pairs", pairs, 3);
    chk("after reset first x1", first_f1, 64'd400);
    chk("after reset last x2", bus.feature_x2_out, 64'h3300_0000_0000_0192);
    tick();

    // Random valid gaps, long job
    x2_tag = 64'hC3C3_0000_0000_0000;
    base_cnt = done_cnt;
    start_job(1000);
    fork
      send(1, 1000, 5000, 30, 0, 1'b1, 200);
      send(2, 1000, 5000, 30, 3, 1'b1, 200);
    join
    wait_done("random", base_cnt, 500);
    chki("random pairs", pairs, 1000);
    chki("random valid outside run", viol, 0);
    chk("random last pair x1", bus.feature_x1_out, 64'd5999);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shortcut_align.md
SHORTCUT_ALIGN -- requirements
Module: shortcut_align

Interface
REQ-001 Parameter FEATURE_WIDTH, default `FEATURE_WIDTH, width of one feature lane; 8 lanes per beat.
REQ-002 Parameter FIFO_DEPTH, default 16, entries per input FIFO; power of two, at least 4.
REQ-003 system_clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start_in  in  1  one-cycle pulse that begins a job; sampled only in IDLE.
REQ-006 total_beats_in  in  16  number of paired beats in the job; sampled with start_in.
REQ-007 x1_data_in  in  FEATURE_WIDTH*8  main-path (conv result) beat.
REQ-008 x1_valid_in / x1_ready_out  in / out  1 / 1  main-path handshake.
REQ-009 x2_data_in  in  FEATURE_WIDTH*8  shortcut-path beat.
REQ-010 x2_valid_in / x2_ready_out  in / out  1 / 1  shortcut-path handshake.
REQ-011 feature_x1_out, feature_x2_out  out  FEATURE_WIDTH*8 each  aligned beat pair fed to the adder stage.
REQ-012 feature_x_valid_out  out  1  pair valid; downstream has no backpressure.
REQ-013 busy_out  out  1  high in RUN.
REQ-014 done_out  out  1  one-cycle pulse at job end.

Function
REQ-015 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start_in with total_beats_in>0.
- IDLE->DONE on start_in with total_beats_in==0.
- RUN->DONE in the cycle after the last pair is emitted.
- DONE->IDLE unconditionally after one cycle.
REQ-016 start_in outside IDLE is ignored.
REQ-017 Per side, a beat transfers when valid and ready are both high at a clock edge. A beat with valid high and ready low is not accepted, and the sender holds it.
REQ-018 xN_ready_out = (state==RUN) && !fifoN_full && (acceptedN < job_total). Computed from registered state only, with no combinational path from valid inputs.
REQ-019 Each side has its own FIFO_DEPTH FIFO and its own 16-bit accepted counter. Counters clear on start; pointers wrap modulo FIFO_DEPTH.
REQ-020 A pair pops when both FIFOs are non-empty (registered occupancy) in RUN.
- feature_x1_out, feature_x2_out and feature_x_valid_out are registered and asserted the next cycle.
- Minimum latency from the later of the two accepts to valid_out is 2 cycles.
- A FIFO may be written and popped in the same cycle; a write into an empty FIFO is not poppable until the next cycle.
REQ-021 When no pop occurs, feature_x_valid_out is 0 and the data outputs hold their last value.
REQ-022 Emitted counter increments per pop. No pop occurs once emitted==job_total.
REQ-023 done_out is high exactly in the DONE state. busy_out is high exactly in the RUN state.
REQ-024 Order is preserved per side: the k-th emitted pair is the k-th x1 beat together with the k-th x2 beat.
REQ-025 Sides may run arbitrarily skewed (up to FIFO_DEPTH beats) without loss. A full side deasserts its ready until the other side catches up.
REQ-026 FIFO occupancy never exceeds FIFO_DEPTH or goes below 0; a push when full or a pop when empty is impossible by construction.

Reset
REQ-027 rst_n low asynchronously forces:
- state IDLE;
- all pointers, occupancies and counters to 0;
- all outputs to 0, including data outputs.
REQ-028 Reset mid-job discards all buffered beats; the first job after reset behaves identically to one from power-up.

Structure
REQ-029 A shared package holds: FSM state encoding (IDLE=0, RUN=1, DONE=2), the beat-count width constant (16) and the FIFO_DEPTH default.
REQ-030 One sub-module, align_fifo, is instantiated twice (x1, x2). It has a registered full/empty interface: push, pop, data, occupancy.

Verification
REQ-031 Lockstep: total=8, both sides valid every cycle with beats 1..8 -> 8 pairs (k,k) on valid_out, first pair 2 cycles after the first accept, done_out pulse 1 cycle after the last pair.
REQ-032 Skew: total=20, x1 sends all 20 at once, x2 starts 30 cycles later -> x1_ready_out falls after 16 accepts, resumes as pairs drain, all 20 pairs in order, no loss.
REQ-033 Zero job: start with total=0 -> done_out high the next cycle, never busy, no valid_out.
REQ-034 Over-supply: total=4, both sides keep valid high for 10 beats -> only 4 accepted per side, ready low afterwards, exactly 4 pairs.
REQ-035 Reset mid-job: total=10, assert rst_n low after 5 pairs -> all outputs 0 immediately; a new job with total=3 yields exactly 3 correct pairs.
REQ-036 Random valid gaps on both sides, total=1000, scoreboard -> pair order and count exact, valid_out never high outside RUN.
